// File: rtl/hynoc_egress_sched_pkg.sv
// Shared types and helpers for the HyNoC egress scheduler.
package hynoc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARB   = 2'd1,
        ST_GRANT = 2'd2
    } sched_state_e;

    // Ceiling log2, never below 1 so a single requester still gets a select bit.
    function automatic int unsigned clog2_min1(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'(1) << i) < 64'(n)) r = i + 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/hynoc_egress_sched_if.sv
// Requester/egress handshake bundle between the ingress side and the egress scheduler.
interface hynoc_egress_sched_if
    import hynoc_pkg::*;
#(
    parameter int unsigned NB_REQ          = 4,
    parameter int unsigned LOG2_FIFO_DEPTH = 5
);
    localparam int unsigned SEL_WIDTH = clog2_min1(NB_REQ);
    localparam int unsigned LVL_WIDTH = LOG2_FIFO_DEPTH + 1;

    logic [NB_REQ-1:0]    req;
    logic [NB_REQ-1:0]    write;
    logic [NB_REQ-1:0]    last;
    logic [LVL_WIDTH-1:0] egress_level;
    logic [NB_REQ-1:0]    grant;
    logic [SEL_WIDTH-1:0] sel;
    logic                 afull;
    logic                 busy;
    logic                 err;

    modport master (
        output req, write, last, egress_level,
        input  grant, sel, afull, busy, err
    );

    modport slave (
        input  req, write, last, egress_level,
        output grant, sel, afull, busy, err
    );
endinterface

// File: rtl/hynoc_egress_sched_rr_pick.sv
// Rotate-priority-rotate picker: first set request at or after ptr, wrapping.
module hynoc_rr_pick
    import hynoc_pkg::*;
#(
    parameter int unsigned NB_REQ = 4
) (
    input  logic [NB_REQ-1:0]                 req,
    input  logic [clog2_min1(NB_REQ)-1:0]     ptr,
    output logic [NB_REQ-1:0]                 pick_c,
    output logic [clog2_min1(NB_REQ)-1:0]     idx_c,
    output logic                              vld_c
);
    localparam int unsigned SEL_WIDTH = clog2_min1(NB_REQ);
    localparam int unsigned OFF_WIDTH = SEL_WIDTH + 1;

    logic [NB_REQ-1:0]    rot;
    logic [SEL_WIDTH-1:0] off;
    logic [OFF_WIDTH-1:0] sum;

    assign vld_c = |req;

    always_comb begin
        rot = NB_REQ'({req, req} >> ptr);
        off = '0;
        for (int i = int'(NB_REQ) - 1; i >= 0; i--) begin
            if (rot[i]) off = SEL_WIDTH'(i);
        end
        // Undo the rotation: offset relative to ptr back to an absolute index.
        sum = OFF_WIDTH'(ptr) + OFF_WIDTH'(off);
        if (sum >= OFF_WIDTH'(NB_REQ)) sum = sum - OFF_WIDTH'(NB_REQ);
        idx_c  = sum[SEL_WIDTH-1:0];
        pick_c = vld_c ? (NB_REQ'(1) << idx_c) : '0;
    end
endmodule

// File: rtl/hynoc_egress_sched.sv
// Packet-level round-robin egress scheduler with registered almost-full.
// Optional idle-grant watchdog: define HYNOC_EGRESS_SCHED_TIMEOUT_EN.
module hynoc_egress_sched
    import hynoc_pkg::*;
#(
    parameter int unsigned NB_REQ          = 4,
    parameter int unsigned LOG2_FIFO_DEPTH = 5,
    parameter int unsigned AFULL_MARGIN    = 4,
    parameter int unsigned PRRA_PIPELINE   = 0,
    parameter int unsigned TIMEOUT         = 64
) (
    input  logic                 router_clk,
    input  logic                 router_arst_n,
    hynoc_egress_sched_if.slave  bus
);
    localparam int unsigned SEL_WIDTH = clog2_min1(NB_REQ);
    localparam int unsigned LVL_WIDTH = LOG2_FIFO_DEPTH + 1;
    localparam logic [LVL_WIDTH-1:0] AFULL_LEVEL =
        LVL_WIDTH'((1 << LOG2_FIFO_DEPTH) - AFULL_MARGIN);

    sched_state_e         state_q, state_d;
    logic [NB_REQ-1:0]    req_q;
    logic [NB_REQ-1:0]    grant_q, grant_d;
    logic [SEL_WIDTH-1:0] sel_q, sel_d;
    logic [SEL_WIDTH-1:0] ptr_q, ptr_d;
    logic [SEL_WIDTH-1:0] pick_idx_q, pick_idx_d;
    logic                 busy_q, busy_d;
    logic                 err_q, err_d;
    logic                 afull_q;

    logic [NB_REQ-1:0]    pick_c;
    logic [SEL_WIDTH-1:0] pick_idx_c;
    logic                 pick_vld_c;
    logic                 wr_sel_c, last_sel_c, req_sel_c, foreign_c, rel_c;
    logic [SEL_WIDTH-1:0] ptr_adv_c;

`ifdef HYNOC_EGRESS_SCHED_TIMEOUT_EN
    localparam int unsigned TMR_WIDTH = clog2_min1(TIMEOUT);
    logic [TMR_WIDTH-1:0] timer_q, timer_d;
`else
    logic unused_timeout;
    assign unused_timeout = ^32'(TIMEOUT);
`endif

    hynoc_rr_pick #(.NB_REQ(NB_REQ)) u_pick (
        .req    (req_q),
        .ptr    (ptr_q),
        .pick_c (pick_c),
        .idx_c  (pick_idx_c),
        .vld_c  (pick_vld_c)
    );

    assign wr_sel_c   = bus.write[sel_q];
    assign last_sel_c = bus.last[sel_q];
    assign req_sel_c  = bus.req[sel_q];
    assign ptr_adv_c  = (sel_q == SEL_WIDTH'(NB_REQ - 1)) ? '0 : sel_q + SEL_WIDTH'(1);
    // Only the granted requester may write, and only while a grant is held.
    assign foreign_c  = (state_q == ST_GRANT) ? |(bus.write & ~grant_q) : |bus.write;

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        sel_d      = sel_q;
        ptr_d      = ptr_q;
        pick_idx_d = pick_idx_q;
        busy_d     = busy_q;
        err_d      = err_q | foreign_c;
        rel_c      = 1'b0;
`ifdef HYNOC_EGRESS_SCHED_TIMEOUT_EN
        timer_d    = '0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (pick_vld_c) begin
                    if (PRRA_PIPELINE != 0) begin
                        pick_idx_d = pick_idx_c;
                        state_d    = ST_ARB;
                    end else begin
                        grant_d = pick_c;
                        sel_d   = pick_idx_c;
                        busy_d  = 1'b1;
                        state_d = ST_GRANT;
                    end
                end
            end
            ST_ARB: begin
                grant_d = NB_REQ'(1) << pick_idx_q;
                sel_d   = pick_idx_q;
                busy_d  = 1'b1;
                state_d = ST_GRANT;
            end
            ST_GRANT: begin
                if (wr_sel_c && last_sel_c) begin
                    rel_c = 1'b1;
                end else if (!req_sel_c && !wr_sel_c) begin
                    rel_c = 1'b1;
                    err_d = 1'b1;
                end
`ifdef HYNOC_EGRESS_SCHED_TIMEOUT_EN
                else if (!wr_sel_c && (timer_q == TMR_WIDTH'(TIMEOUT - 1))) begin
                    rel_c = 1'b1;
                    err_d = 1'b1;
                end else begin
                    timer_d = wr_sel_c ? '0 : timer_q + TMR_WIDTH'(1);
                end
`endif
            end
            default: state_d = ST_IDLE;
        endcase
        // sel keeps its last value on release; it only moves with a new grant.
        if (rel_c) begin
            state_d = ST_IDLE;
            grant_d = '0;
            busy_d  = 1'b0;
            ptr_d   = ptr_adv_c;
        end
    end

    always_ff @(posedge router_clk or negedge router_arst_n) begin
        if (!router_arst_n) begin
            state_q    <= ST_IDLE;
            req_q      <= '0;
            grant_q    <= '0;
            sel_q      <= '0;
            ptr_q      <= '0;
            pick_idx_q <= '0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
            afull_q    <= 1'b1;
`ifdef HYNOC_EGRESS_SCHED_TIMEOUT_EN
            timer_q    <= '0;
`endif
        end else begin
            state_q    <= state_d;
            req_q      <= bus.req;
            grant_q    <= grant_d;
            sel_q      <= sel_d;
            ptr_q      <= ptr_d;
            pick_idx_q <= pick_idx_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
            afull_q    <= (bus.egress_level >= AFULL_LEVEL);
`ifdef HYNOC_EGRESS_SCHED_TIMEOUT_EN
            timer_q    <= timer_d;
`endif
        end
    end

    assign bus.grant = grant_q;
    assign bus.sel   = sel_q;
    assign bus.busy  = busy_q;
    assign bus.err   = err_q;
    assign bus.afull = afull_q;
endmodule

// File: tb/tb_hynoc_egress_sched.sv
// Directed self-checking bench for hynoc_egress_sched (NB_REQ=4, 32-deep FIFO).
module tb_hynoc_egress_sched;
    localparam int unsigned NB_REQ = 4;
    localparam int unsigned LFD    = 5;
    localparam int unsigned MARGIN = 4;
    localparam int unsigned PRRA   = 0;
    localparam int unsigned TMO    = 8;
    localparam int LAT = (PRRA != 0) ? 3 : 2;
    localparam int GAP = (PRRA != 0) ? 2 : 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    hynoc_egress_sched_if #(.NB_REQ(NB_REQ), .LOG2_FIFO_DEPTH(LFD)) bus ();

    hynoc_egress_sched #(
        .NB_REQ(NB_REQ), .LOG2_FIFO_DEPTH(LFD), .AFULL_MARGIN(MARGIN),
        .PRRA_PIPELINE(PRRA), .TIMEOUT(TMO)
    ) dut (
        .router_clk    (clk),
        .router_arst_n (rst_n),
        .bus           (bus)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        bus.req = '0; bus.write = '0; bus.last = '0; bus.egress_level = '0;
        rst_n = 1'b0;
        tick(3);
        rst_n = 1'b1;
        #1;
        checks++; if (bus.grant !== 4'b0000) begin errors++; $display("FAIL reset_grant got=%b exp=0000", bus.grant); end
        checks++; if (bus.sel !== 2'd0) begin errors++; $display("FAIL reset_sel got=%0d exp=0", bus.sel); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.afull !== 1'b1) begin errors++; $display("FAIL reset_afull got=%b exp=1", bus.afull); end
        checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", bus.err); end
        tick(1);
        checks++; if (bus.afull !== 1'b0) begin errors++; $display("FAIL reset_afull_drop got=%b exp=0", bus.afull); end
    endtask

    task automatic test_afull;
        bus.egress_level = 6'd27;
        tick(1);
        checks++; if (bus.afull !== 1'b0) begin errors++; $display("FAIL afull_27 got=%b exp=0", bus.afull); end
        bus.egress_level = 6'd28;
        #1;
        checks++; if (bus.afull !== 1'b0) begin errors++; $display("FAIL afull_lag got=%b exp=0", bus.afull); end
        tick(1);
        checks++; if (bus.afull !== 1'b1) begin errors++; $display("FAIL afull_28 got=%b exp=1", bus.afull); end
        bus.egress_level = 6'd32;
        tick(1);
        checks++; if (bus.afull !== 1'b1) begin errors++; $display("FAIL afull_32 got=%b exp=1", bus.afull); end
        bus.egress_level = 6'd0;
        tick(1);
        checks++; if (bus.afull !== 1'b0) begin errors++; $display("FAIL afull_0 got=%b exp=0", bus.afull); end
    endtask

    task automatic test_fairness;
        bus.req = 4'b1111;
        tick(LAT);
        for (int p = 0; p < 5; p++) begin
            logic [3:0] exp_g;
            exp_g = 4'(1) << (p % 4);
            checks++; if (bus.grant !== exp_g || bus.sel !== 2'(p % 4)) begin
                errors++; $display("FAIL fair_grant p=%0d got=%b/%0d exp=%b/%0d", p, bus.grant, bus.sel, exp_g, p % 4);
            end
            for (int f = 0; f < 3; f++) begin
                bus.write = exp_g;
                bus.last  = (f == 2) ? exp_g : 4'b0000;
                if (p == 4 && f == 2) bus.req = '0;
                tick(1);
                if (f < 2) begin
                    checks++; if (bus.grant !== exp_g) begin errors++; $display("FAIL fair_hold p=%0d f=%0d got=%b exp=%b", p, f, bus.grant, exp_g); end
                end
            end
            bus.write = '0; bus.last = '0;
            checks++; if (bus.grant !== 4'b0000 || bus.busy !== 1'b0) begin
                errors++; $display("FAIL fair_gap p=%0d got=%b busy=%b exp=0000 busy=0", p, bus.grant, bus.busy);
            end
            tick(GAP);
        end
        tick(2);
        checks++; if (bus.grant !== 4'b0000) begin errors++; $display("FAIL fair_quiet got=%b exp=0000", bus.grant); end
    endtask

    task automatic test_latency;
        bus.req = 4'b0100;
        tick(LAT - 1);
        checks++; if (bus.grant !== 4'b0000) begin errors++; $display("FAIL lat_early got=%b exp=0000", bus.grant); end
        tick(1);
        checks++; if (bus.grant !== 4'b0100 || bus.sel !== 2'd2) begin
            errors++; $display("FAIL lat_grant got=%b/%0d exp=0100/2", bus.grant, bus.sel);
        end
        bus.write = 4'b0100; bus.last = 4'b0100; bus.req = '0;
        tick(1);
        bus.write = '0; bus.last = '0;
        checks++; if (bus.grant !== 4'b0000 || bus.err !== 1'b0) begin
            errors++; $display("FAIL lat_release got=%b err=%b exp=0000 err=0", bus.grant, bus.err);
        end
    endtask

    task automatic test_protocol_errors;
        bus.req = 4'b0001;
        tick(LAT);
        checks++; if (bus.grant !== 4'b0001) begin errors++; $display("FAIL proto_grant got=%b exp=0001", bus.grant); end
        bus.write = 4'b0010;
        tick(1);
        bus.write = '0;
        checks++; if (bus.err !== 1'b1 || bus.grant !== 4'b0001) begin
            errors++; $display("FAIL foreign_write got=err%b/%b exp=err1/0001", bus.err, bus.grant);
        end
        tick(3);
        checks++; if (bus.err !== 1'b1 || bus.grant !== 4'b0001) begin
            errors++; $display("FAIL err_sticky got=err%b/%b exp=err1/0001", bus.err, bus.grant);
        end
        // Asynchronous reset while the packet is in progress.
        rst_n = 1'b0;
        #1;
        checks++; if (bus.grant !== 4'b0000 || bus.busy !== 1'b0 || bus.err !== 1'b0 || bus.afull !== 1'b1) begin
            errors++; $display("FAIL midreset got=%b busy=%b err=%b afull=%b exp=0000 0 0 1", bus.grant, bus.busy, bus.err, bus.afull);
        end
        tick(1);
        rst_n = 1'b1;
        tick(LAT);
        checks++; if (bus.grant !== 4'b0001 || bus.err !== 1'b0) begin
            errors++; $display("FAIL regrant got=%b err=%b exp=0001 err=0", bus.grant, bus.err);
        end
        bus.req = '0;
        tick(1);
        checks++; if (bus.grant !== 4'b0000 || bus.busy !== 1'b0 || bus.err !== 1'b1) begin
            errors++; $display("FAIL abort got=%b busy=%b err=%b exp=0000 0 1", bus.grant, bus.busy, bus.err);
        end
    endtask

    task automatic test_timeout;
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        bus.req = 4'b0010;
        tick(LAT);
        checks++; if (bus.grant !== 4'b0010 || bus.sel !== 2'd1) begin
            errors++; $display("FAIL tmo_grant got=%b/%0d exp=0010/1", bus.grant, bus.sel);
        end
`ifdef HYNOC_EGRESS_SCHED_TIMEOUT_EN
        tick(TMO - 1);
        checks++; if (bus.grant !== 4'b0010 || bus.err !== 1'b0) begin
            errors++; $display("FAIL tmo_early got=%b err=%b exp=0010 err=0", bus.grant, bus.err);
        end
        tick(1);
        checks++; if (bus.grant !== 4'b0000 || bus.err !== 1'b1) begin
            errors++; $display("FAIL tmo_release got=%b err=%b exp=0000 err=1", bus.grant, bus.err);
        end
`else
        tick(20);
        checks++; if (bus.grant !== 4'b0010 || bus.err !== 1'b0) begin
            errors++; $display("FAIL tmo_hold got=%b err=%b exp=0010 err=0", bus.grant, bus.err);
        end
`endif
        bus.req = '0;
    endtask

    initial begin
        test_reset();
        test_afull();
        test_fairness();
        test_latency();
        test_protocol_errors();
        test_timeout();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired before end of sequence");
        $fatal(1);
    end
endmodule

// File: doc/hynoc_egress_sched.md
# hynoc_egress_sched

Packet-level round-robin scheduler for one HyNoC egress port. It arbitrates among the NB_REQ ingress requesters that target this egress and holds a one-hot grant for a whole packet. It drives the flit-mux select and produces the registered almost-full back-pressure seen by the ingresses. One instance sits beside each egress FIFO inside the router.

## Interface
- NB_REQ, 4, number of requesters (router NB_PORTS-1)
- LOG2_FIFO_DEPTH, 5, log2 depth of the egress FIFO
- AFULL_MARGIN, 4, free slots below which afull asserts
- PRRA_PIPELINE, 0, 0: grant 2 cycles after request; 1: 3 cycles
- TIMEOUT, 64, idle-grant watchdog limit in cycles; used only with the macro
- SEL_WIDTH, clog2(NB_REQ) (min 1), width of sel

Ports:
- router_clk  in  1  router clock; the only clock
- router_arst_n  in  1  asynchronous, active-low reset
- req  in  NB_REQ  per-requester packet request, level
- write  in  NB_REQ  per-requester flit-valid strobe
- last  in  NB_REQ  flit MSB (end-of-packet) of each requester, qualified by write
- egress_level  in  LOG2_FIFO_DEPTH+1  egress FIFO fill level
- grant  out  NB_REQ  one-hot grant; reset 0
- sel  out  SEL_WIDTH  index of granted requester, mux select; reset 0
- afull  out  1  egress almost full; reset 1
- busy  out  1  a grant is held; reset 0
- err  out  1  sticky protocol error; reset 0

## Operation
- FSM states:
  - IDLE: no grant held.
  - ARB: present only when PRRA_PIPELINE=1.
  - GRANT: grant held.
- Request capture: req is registered every cycle into req_q.
- IDLE: when req_q is nonzero, pick the first set bit at or after ptr, wrapping modulo NB_REQ.
  - PRRA_PIPELINE=0: load grant/sel and go to GRANT.
  - PRRA_PIPELINE=1: register the pick, go to ARB, then load grant/sel next cycle.
- GRANT, release condition: write[sel] & last[sel] releases the grant the same edge. Go to IDLE and set ptr = sel+1 mod NB_REQ.
- GRANT, abort: req[sel] low with no write[sel] in a cycle is an abort. Release, advance ptr and set err.
- Foreign write: a write[k] with k != sel, or any write in IDLE/ARB, sets err. The flit is otherwise ignored (not counted).
- Re-request: a requester whose packet just ended may request again. It is granted only after the others already requesting, as ptr has passed it.
- ptr reset value is 0.
- afull is registered from egress_level >= 2^LOG2_FIFO_DEPTH - AFULL_MARGIN. Compare at LOG2_FIFO_DEPTH+1 bits; a level of exactly 2^LOG2_FIFO_DEPTH (full) also asserts.
- err clears only on reset.
- Reset asserted mid-packet: all outputs return to their reset values immediately (asynchronous). Deassertion is synchronised by the integrator.

## Timing
- req rising at edge N is sampled into req_q at edge N+1.
- grant is visible after edge N+2 (PRRA_PIPELINE=0) or N+3 (PRRA_PIPELINE=1).
- Release is visible the cycle after the last flit. A new grant needs a minimum of 1 idle cycle (2 with PRRA_PIPELINE=1). Back-to-back packets are not overlapped.
- sel changes only when grant changes, and the two change on the same edge.
- afull lags egress_level by 1 cycle. AFULL_MARGIN must be at least 3 to absorb in-flight flits.

## Configuration
- Macro HYNOC_EGRESS_SCHED_TIMEOUT_EN, defined: a counter runs in GRANT.
  - It clears on write[sel] and counts otherwise.
  - At TIMEOUT, the grant is force-released, ptr advances and err is set.
- Not defined: no counter; a grant is held indefinitely until last or abort. TIMEOUT is ignored.

## Structure
- Package hynoc_pkg holds:
  - FSM state encoding (IDLE, ARB, GRANT)
  - clog2 helper for SEL_WIDTH
- Sub-module hynoc_rr_pick: combinational rotate-priority-rotate. Inputs are the request vector and ptr; outputs are the one-hot pick and its index.

## Test plan
- Reset: after router_arst_n is released, grant=0, sel=0, busy=0, afull=1, err=0. afull drops one cycle after egress_level=0.
- Fairness:
  - Setup: NB_REQ=4, req=4'b1111 held; every packet is 3 flits ending with last.
  - Required: grants rotate 0,1,2,3,0. Each grant lasts exactly until its last flit, with a 1-cycle idle gap.
- Latency: a single req[2] rises → grant=4'b0100 and sel=2 two cycles later (PRRA_PIPELINE=0), three cycles later (PRRA_PIPELINE=1).
- afull threshold, with LOG2_FIFO_DEPTH=5 and AFULL_MARGIN=4:
  - egress_level 27 → afull=0.
  - 28 → afull=1 next cycle.
  - 32 → afull=1.
- Protocol errors:
  - write[1] while grant=4'b0001 → err=1 and stays set; grant unchanged.
  - req[0] dropped mid-packet → release and err=1.
- Timeout (macro defined, TIMEOUT=8): granted requester issues no write → forced release after 8 cycles and err=1. Without the macro, the grant persists.
